// File: rtl/test_seq_pkg.sv
// -----------------------------------------------------------------------------
// test_seq_pkg
// Shared definitions for the arithmetic-testbench stimulus sequencer.
//   seq_state_t  : sequencer FSM state encoding
//   XS_SHIFT_*   : xorshift step constants (x^=x<<A; x^=x>>B; x^=x<<C)
// -----------------------------------------------------------------------------
package test_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WARMUP = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_t;

    localparam int XS_SHIFT_A = 13;
    localparam int XS_SHIFT_B = 17;
    localparam int XS_SHIFT_C = 5;

endpackage

// File: rtl/test_seq_xorshift.sv
// -----------------------------------------------------------------------------
// stim_xorshift
// One WIDTH-bit xorshift operand generator.
// Ports:
//   clk      in   clock
//   reset    in   synchronous active-high reset, loads SEED
//   load     in   reload SEED (start of a run)
//   advance  in   take one xorshift step
//   value    out  current generator value (registered)
// -----------------------------------------------------------------------------
module stim_xorshift
    import test_seq_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] step_1;
    logic [WIDTH-1:0] step_2;
    logic [WIDTH-1:0] next_value;

    always_comb begin
        step_1     = value  ^ (value  << XS_SHIFT_A);
        step_2     = step_1 ^ (step_1 >> XS_SHIFT_B);
        next_value = step_2 ^ (step_2 << XS_SHIFT_C);
    end

    // Load has priority over advance so a restart always begins on the seed.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= SEED;
        end else if (load) begin
            value <= SEED;
        end else if (advance) begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/test_seq.sv
// -----------------------------------------------------------------------------
// test_seq
// Self-checking stimulus sequencer: issues NUM_VEC pseudo-random operand pairs
// once the monitor is ready, aligns the monitor's diff word to each issued
// vector through a DIFF_LAT-deep valid pipe, and reports error statistics.
// Optional build macro: TEST_SEQ_STOP_ON_ERR_EN - end the run on the first
// failing check (abort flagged, only that error counted).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   i_start               start pulse (honoured in IDLE and DONE only)
//   i_mon_ready           monitor ready; low during RUN/DRAIN aborts
//   i_diff                monitor difference word, nonzero = mismatch
//   o_dut_ia, o_dut_ib    operands to DUT and monitor
//   o_busy, o_done        run in progress / run finished
//   o_pass, o_abort       clean completion / early termination
//   o_err_count           number of failing vectors
//   o_first_err           index of first failing vector, all-ones if none
// -----------------------------------------------------------------------------
module test_seq
    import test_seq_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               NUM_VEC  = 1024,
    parameter int               DIFF_LAT = 4,
    parameter logic [WIDTH-1:0] SEED_A   = WIDTH'(1),
    parameter logic [WIDTH-1:0] SEED_B   = WIDTH'(2),
    parameter int               VEC_W    = $clog2(NUM_VEC + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_mon_ready,
    input  logic [WIDTH-1:0] i_diff,
    output logic [WIDTH-1:0] o_dut_ia,
    output logic [WIDTH-1:0] o_dut_ib,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic             o_abort,
    output logic [VEC_W-1:0] o_err_count,
    output logic [VEC_W-1:0] o_first_err
);

    localparam int               LAT_W    = $clog2(DIFF_LAT + 1);
    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);
    localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(DIFF_LAT - 1);

    seq_state_t          state;
    logic [VEC_W-1:0]    issue_cnt;
    logic [LAT_W-1:0]    drain_cnt;
    logic [DIFF_LAT-1:0] valid_sr;
    logic [VEC_W-1:0]    check_idx;

    logic in_flight;
    logic check_valid;
    logic check_fail;
    logic ready_drop;
    logic err_stop;
    logic gen_load;
    logic gen_advance;

    always_comb begin
        in_flight   = (state == ST_RUN) || (state == ST_DRAIN);
        check_valid = valid_sr[DIFF_LAT-1];
        check_fail  = check_valid && (i_diff != '0);
        ready_drop  = in_flight && !i_mon_ready;
`ifdef TEST_SEQ_STOP_ON_ERR_EN
        err_stop    = in_flight && !ready_drop && check_fail;
`else
        err_stop    = 1'b0;
`endif
        gen_load    = ((state == ST_IDLE) || (state == ST_DONE)) && i_start;
        // The last vector is not stepped past, so DRAIN holds it on the bus.
        gen_advance = (state == ST_RUN) && !ready_drop && !err_stop &&
                      (issue_cnt != LAST_VEC);
    end

    stim_xorshift #(
        .WIDTH (WIDTH),
        .SEED  (SEED_A)
    ) u_gen_a (
        .clk     (clk),
        .reset   (reset),
        .load    (gen_load),
        .advance (gen_advance),
        .value   (o_dut_ia)
    );

    stim_xorshift #(
        .WIDTH (WIDTH),
        .SEED  (SEED_B)
    ) u_gen_b (
        .clk     (clk),
        .reset   (reset),
        .load    (gen_load),
        .advance (gen_advance),
        .value   (o_dut_ib)
    );

    // Sequencer FSM with registered status outputs. The check for the vector
    // leaving the valid pipe is folded into the RUN/DRAIN branch so that the
    // last check and the DONE transition update in the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            issue_cnt   <= '0;
            drain_cnt   <= '0;
            valid_sr    <= '0;
            check_idx   <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_pass      <= 1'b0;
            o_abort     <= 1'b0;
            o_err_count <= '0;
            o_first_err <= '1;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        state       <= ST_WARMUP;
                        issue_cnt   <= '0;
                        drain_cnt   <= '0;
                        valid_sr    <= '0;
                        check_idx   <= '0;
                        o_busy      <= 1'b1;
                        o_done      <= 1'b0;
                        o_pass      <= 1'b0;
                        o_abort     <= 1'b0;
                        o_err_count <= '0;
                        o_first_err <= '1;
                    end
                end

                ST_WARMUP: begin
                    if (i_mon_ready) begin
                        state     <= ST_RUN;
                        issue_cnt <= '0;
                    end
                end

                ST_RUN, ST_DRAIN: begin
                    if (ready_drop) begin
                        // In-flight checks are thrown away with the pipe.
                        state    <= ST_DONE;
                        valid_sr <= '0;
                        o_busy   <= 1'b0;
                        o_done   <= 1'b1;
                        o_pass   <= 1'b0;
                        o_abort  <= 1'b1;
                    end else begin
                        if (check_valid) begin
                            check_idx <= check_idx + 1'b1;
                            if (check_fail) begin
                                o_err_count <= o_err_count + 1'b1;
                                if (o_err_count == '0) begin
                                    o_first_err <= check_idx;
                                end
                            end
                        end

                        if (err_stop) begin
                            state    <= ST_DONE;
                            valid_sr <= '0;
                            o_busy   <= 1'b0;
                            o_done   <= 1'b1;
                            o_pass   <= 1'b0;
                            o_abort  <= 1'b1;
                        end else if (state == ST_RUN) begin
                            valid_sr <= (valid_sr << 1) | DIFF_LAT'(1);
                            if (issue_cnt == LAST_VEC) begin
                                state     <= ST_DRAIN;
                                drain_cnt <= '0;
                            end else begin
                                issue_cnt <= issue_cnt + 1'b1;
                            end
                        end else begin
                            valid_sr <= valid_sr << 1;
                            if (drain_cnt == LAST_LAT) begin
                                state  <= ST_DONE;
                                o_busy <= 1'b0;
                                o_done <= 1'b1;
                                o_pass <= (o_err_count == '0) && !check_fail;
                            end else begin
                                drain_cnt <= drain_cnt + 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
